// File: rtl/sum_accumulator.sv
// sum_accumulator: sums NUM_SAMPLES 5-bit {c_out, sum} adder results into one 8-bit total
// and counts how many of those samples carried out.
module sum_accumulator #(
    parameter int NUM_SAMPLES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       in_valid,
    input  logic [3:0] in_sum,
    input  logic       in_c_out,
    output logic       in_ready,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_acc,
    output logic [3:0] out_carry_cnt
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    state_t     state_q, state_d;
    logic [7:0] acc_q, acc_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] carry_q, carry_d;
    logic       accept, last, zero;
    always_comb begin
        accept  = in_valid && in_ready && !clear;
        last    = cnt_q == 4'(NUM_SAMPLES - 1);
        // a taken result and a clear both return every register to the idle zero state
        zero    = clear || (state_q == DONE && out_ready);
        state_d = zero ? IDLE : accept ? (last ? DONE : ACCUM) : state_q;
        acc_d   = zero ? '0 : accept ? acc_q + {3'b000, in_c_out, in_sum} : acc_q;
        cnt_d   = zero ? '0 : accept ? cnt_q + 4'd1 : cnt_q;
        carry_d = zero ? '0 : accept ? carry_q + {3'b000, in_c_out} : carry_q;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            carry_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
        end
    end
    assign in_ready      = state_q != DONE;
    assign out_valid     = state_q == DONE;
    assign out_acc       = acc_q;
    assign out_carry_cnt = carry_q;
endmodule

// File: tb/tb_sum_accumulator.sv
// tb_sum_accumulator: three accumulators (N=4, 8, 1) checked every cycle against a
// sample-list model, plus hand-computed expectations for the directed scenarios.
module tb_sum_accumulator;
    logic       clk = 0;
    logic       reset_n = 0;
    logic       clear = 0;
    logic       in_valid = 0;
    logic       out_ready = 0;
    logic       in_c_out = 0;
    logic [3:0] in_sum = 0;
    int         sel = 0;
    logic [2:0] iv, ordy, ir, ov;
    logic [7:0] acc [3];
    logic [3:0] cc [3];
    int         ns [3] = '{4, 8, 1};
    int         m_n [3], m_sum [3], m_cc [3];
    int         total = 0, bad = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_sel
        assign iv[k]   = in_valid && sel == k;
        assign ordy[k] = out_ready && sel == k;
    end

    sum_accumulator #(.NUM_SAMPLES(4)) dut0 (.clk(clk), .reset_n(reset_n), .clear(clear),
        .in_valid(iv[0]), .in_sum(in_sum), .in_c_out(in_c_out), .in_ready(ir[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_acc(acc[0]), .out_carry_cnt(cc[0]));
    sum_accumulator #(.NUM_SAMPLES(8)) dut1 (.clk(clk), .reset_n(reset_n), .clear(clear),
        .in_valid(iv[1]), .in_sum(in_sum), .in_c_out(in_c_out), .in_ready(ir[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_acc(acc[1]), .out_carry_cnt(cc[1]));
    sum_accumulator #(.NUM_SAMPLES(1)) dut2 (.clk(clk), .reset_n(reset_n), .clear(clear),
        .in_valid(iv[2]), .in_sum(in_sum), .in_c_out(in_c_out), .in_ready(ir[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_acc(acc[2]), .out_carry_cnt(cc[2]));

    task automatic chk(string name, int k, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s dut%0d: got %0d expected %0d at %0t", name, k, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_n[k] = 0;
            m_sum[k] = 0;
            m_cc[k] = 0;
        end
    endtask

    // A group is complete once it holds N samples; until taken it refuses new ones.
    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            if (clear || (m_n[k] == ns[k] && ordy[k])) begin
                m_n[k] = 0;
                m_sum[k] = 0;
                m_cc[k] = 0;
            end else if (m_n[k] < ns[k] && iv[k]) begin
                m_n[k]++;
                m_sum[k] += 16 * int'(in_c_out) + int'(in_sum);
                m_cc[k] += int'(in_c_out);
            end
        end
    endtask

    task automatic compare();
        for (int k = 0; k < 3; k++) begin
            bit done = m_n[k] == ns[k];
            chk("in_ready", k, int'(ir[k]), int'(!done));
            chk("out_valid", k, int'(ov[k]), int'(done));
            if (done || m_n[k] == 0) begin
                chk("out_acc", k, int'(acc[k]), m_sum[k]);
                chk("out_carry_cnt", k, int'(cc[k]), m_cc[k]);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic send(logic c, logic [3:0] s);
        in_valid = 1;
        in_c_out = c;
        in_sum = s;
        tick();
    endtask

    task automatic take();
        in_valid = 0;
        out_ready = 1;
        tick();
        out_ready = 0;
    endtask

    task automatic async_reset_pulse(int k);
        #1 reset_n = 0;
        #1;
        chk("rst out_valid", k, int'(ov[k]), 0);
        chk("rst out_acc", k, int'(acc[k]), 0);
        chk("rst out_carry_cnt", k, int'(cc[k]), 0);
        chk("rst in_ready", k, int'(ir[k]), 1);
        model_reset();
        #1 reset_n = 1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", 0, int'(ov[0]), 0);
        chk("reset in_ready", 0, int'(ir[0]), 1);
        chk("reset out_acc", 0, int'(acc[0]), 0);
        reset_n = 1;
        tick();

        // nominal N=4
        sel = 0;
        send(0, 15); send(1, 14); send(1, 15); send(0, 0);
        in_valid = 0;
        chk("nominal out_valid", 0, int'(ov[0]), 1);
        chk("nominal out_acc", 0, int'(acc[0]), 76);
        chk("nominal carry", 0, int'(cc[0]), 2);
        chk("nominal in_ready", 0, int'(ir[0]), 0);
        take();
        chk("nominal taken", 0, int'(ov[0]), 0);

        // maximum N=8 with a held result and upstream still offering data
        sel = 1;
        repeat (8) send(1, 15);
        in_valid = 1; in_c_out = 0; in_sum = 1;
        repeat (5) tick();
        chk("max out_acc", 1, int'(acc[1]), 248);
        chk("max carry", 1, int'(cc[1]), 8);
        chk("max in_ready", 1, int'(ir[1]), 0);
        take();

        // stall between samples 2 and 3
        sel = 0;
        send(0, 5); send(0, 5);
        in_valid = 0;
        repeat (3) tick();
        send(0, 5);
        chk("stall early", 0, int'(ov[0]), 0);
        send(0, 5);
        in_valid = 0;
        chk("stall out_valid", 0, int'(ov[0]), 1);
        chk("stall out_acc", 0, int'(acc[0]), 20);
        take();

        // clear wins over a coincident sample
        send(1, 3); send(0, 7);
        clear = 1; in_valid = 1; in_c_out = 0; in_sum = 9;
        tick();
        clear = 0;
        chk("clear idle acc", 0, int'(acc[0]), 0);
        repeat (4) send(0, 1);
        in_valid = 0;
        chk("clear out_acc", 0, int'(acc[0]), 4);
        chk("clear carry", 0, int'(cc[0]), 0);
        clear = 1;
        tick();
        clear = 0;
        chk("clear done discards", 0, int'(ov[0]), 0);
        send(0, 6); send(0, 6); send(0, 6); send(0, 6);
        in_valid = 0;
        clear = 1; out_ready = 1;
        tick();
        clear = 0; out_ready = 0;
        chk("clear+take in_ready", 0, int'(ir[0]), 1);

        // asynchronous reset in ACCUM and in DONE
        send(1, 2); send(0, 3);
        in_valid = 0;
        async_reset_pulse(0);
        send(0, 2); send(0, 4); send(1, 6); send(0, 8);
        in_valid = 0;
        chk("post-reset out_acc", 0, int'(acc[0]), 36);
        async_reset_pulse(0);
        send(0, 1); send(0, 2); send(0, 3); send(0, 4);
        in_valid = 0;
        chk("post-reset2 out_acc", 0, int'(acc[0]), 10);
        chk("post-reset2 out_valid", 0, int'(ov[0]), 1);
        take();

        // N=1 streaming with out_ready held
        sel = 2;
        out_ready = 1;
        send(0, 10);
        chk("n1 first acc", 2, int'(acc[2]), 10);
        chk("n1 first bubble", 2, int'(ir[2]), 0);
        send(1, 0);
        chk("n1 taken", 2, int'(ov[2]), 0);
        chk("n1 ready", 2, int'(ir[2]), 1);
        tick();
        chk("n1 second acc", 2, int'(acc[2]), 16);
        chk("n1 second valid", 2, int'(ov[2]), 1);
        in_valid = 0;
        tick();
        out_ready = 0;
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
